// File: rtl/garage_gate_controller.sv
// Sequences the shared garage gate lane between entry and exit requesters.
// Optional obstruction hold (HOLD state, obstruct port) is enabled by `define GATE_SAFETY_EN.
module garage_gate_controller #(
  parameter int OPEN_CYCLES  = 4,
  parameter int PASS_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic entry_req,
  input  logic exit_req,
  input  logic pass_sensor,
  input  logic full_flag,
  input  logic empty_flag,
`ifdef GATE_SAFETY_EN
  input  logic obstruct,
`endif
  output logic gate_open,
  output logic entry_grant,
  output logic exit_grant,
  output logic entry_detected,
  output logic exit_detected,
  output logic entry_denied,
  output logic timeout_err,
  output logic busy
);
  localparam int TIMER_MAX = (OPEN_CYCLES > PASS_TIMEOUT) ? OPEN_CYCLES : PASS_TIMEOUT;
  localparam int TW = $clog2(TIMER_MAX + 1);
  localparam logic [TW-1:0] OPEN_LAST = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] PASS_LAST = TW'(PASS_TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_OPENING = 3'd1,
    S_PASSING = 3'd2,
    S_CLOSING = 3'd3,
    S_HOLD    = 3'd4
  } state_e;

  typedef enum logic {
    SIDE_ENTRY = 1'b0,
    SIDE_EXIT  = 1'b1
  } side_e;

  state_e        state_q, state_d;
  side_e         last_served_q, last_served_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          gate_open_q, gate_open_d;
  logic          entry_grant_q, entry_grant_d;
  logic          exit_grant_q, exit_grant_d;
  logic          entry_detected_q, entry_detected_d;
  logic          exit_detected_q, exit_detected_d;
  logic          entry_denied_q, entry_denied_d;
  logic          timeout_err_q, timeout_err_d;
  logic          busy_q, busy_d;
  logic          obstruct_s;
  logic          entry_ok_s;
  logic          exit_ok_s;

`ifdef GATE_SAFETY_EN
  assign obstruct_s = obstruct;
`else
  assign obstruct_s = 1'b0;
`endif

  assign entry_ok_s = entry_req & ~full_flag;
  assign exit_ok_s  = exit_req & ~empty_flag;

  // last_served doubles as the owner of the lane for the whole transaction
  always_comb begin
    state_d          = state_q;
    last_served_d    = last_served_q;
    entry_detected_d = 1'b0;
    exit_detected_d  = 1'b0;
    timeout_err_d    = 1'b0;
    entry_denied_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (entry_ok_s && exit_ok_s) begin
          state_d       = S_OPENING;
          last_served_d = (last_served_q == SIDE_ENTRY) ? SIDE_EXIT : SIDE_ENTRY;
        end else if (entry_ok_s) begin
          state_d       = S_OPENING;
          last_served_d = SIDE_ENTRY;
        end else if (exit_ok_s) begin
          state_d       = S_OPENING;
          last_served_d = SIDE_EXIT;
        end else begin
          entry_denied_d = entry_req & full_flag;
        end
      end
      S_OPENING: begin
        if (timer_q == OPEN_LAST) begin
          state_d = S_PASSING;
        end else begin
          state_d = S_OPENING;
        end
      end
      S_PASSING: begin
        if (pass_sensor) begin
          state_d          = S_CLOSING;
          entry_detected_d = (last_served_q == SIDE_ENTRY);
          exit_detected_d  = (last_served_q == SIDE_EXIT);
        end else if (timer_q == PASS_LAST) begin
          state_d       = S_CLOSING;
          timeout_err_d = 1'b1;
        end else begin
          state_d = S_PASSING;
        end
      end
      S_CLOSING: begin
        if (obstruct_s) begin
          state_d = S_HOLD;
        end else if (timer_q == OPEN_LAST) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_CLOSING;
        end
      end
      S_HOLD: begin
        if (!obstruct_s) begin
          state_d = S_CLOSING;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Timer restarts on every state change and idles at zero in IDLE and HOLD
  always_comb begin
    if ((state_d != state_q) || (state_q == S_IDLE) || (state_q == S_HOLD)) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TIMER_ONE;
    end
  end

  // Level outputs are registered from the next state so they align with it
  always_comb begin
    busy_d        = (state_d != S_IDLE);
    gate_open_d   = (state_d == S_OPENING) || (state_d == S_PASSING) || (state_d == S_HOLD);
    entry_grant_d = busy_d && (last_served_d == SIDE_ENTRY);
    exit_grant_d  = busy_d && (last_served_d == SIDE_EXIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      last_served_q    <= SIDE_ENTRY;
      timer_q          <= '0;
      gate_open_q      <= 1'b0;
      entry_grant_q    <= 1'b0;
      exit_grant_q     <= 1'b0;
      entry_detected_q <= 1'b0;
      exit_detected_q  <= 1'b0;
      entry_denied_q   <= 1'b0;
      timeout_err_q    <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      last_served_q    <= last_served_d;
      timer_q          <= timer_d;
      gate_open_q      <= gate_open_d;
      entry_grant_q    <= entry_grant_d;
      exit_grant_q     <= exit_grant_d;
      entry_detected_q <= entry_detected_d;
      exit_detected_q  <= exit_detected_d;
      entry_denied_q   <= entry_denied_d;
      timeout_err_q    <= timeout_err_d;
      busy_q           <= busy_d;
    end
  end

  assign gate_open      = gate_open_q;
  assign entry_grant    = entry_grant_q;
  assign exit_grant     = exit_grant_q;
  assign entry_detected = entry_detected_q;
  assign exit_detected  = exit_detected_q;
  assign entry_denied   = entry_denied_q;
  assign timeout_err    = timeout_err_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_garage_gate_controller.sv
// Scoreboard bench for garage_gate_controller: a transaction-level model predicts
// output events and their cycles; a monitor pops and compares them as the DUT shows them.
module tb_garage_gate_controller;
  localparam int OC = 4;
  localparam int PT = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic entry_req = 1'b0;
  logic exit_req = 1'b0;
  logic pass_sensor = 1'b0;
  logic full_flag = 1'b0;
  logic empty_flag = 1'b0;
  logic obstruct = 1'b0;
  logic gate_open, entry_grant, exit_grant, entry_detected, exit_detected;
  logic entry_denied, timeout_err, busy;

  garage_gate_controller #(.OPEN_CYCLES(OC), .PASS_TIMEOUT(PT)) dut (
    .clk(clk),
    .reset(reset),
    .entry_req(entry_req),
    .exit_req(exit_req),
    .pass_sensor(pass_sensor),
    .full_flag(full_flag),
    .empty_flag(empty_flag),
`ifdef GATE_SAFETY_EN
    .obstruct(obstruct),
`endif
    .gate_open(gate_open),
    .entry_grant(entry_grant),
    .exit_grant(exit_grant),
    .entry_detected(entry_detected),
    .exit_detected(exit_detected),
    .entry_denied(entry_denied),
    .timeout_err(timeout_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {
    EV_GRANT_EN, EV_GRANT_EX, EV_GATE_UP, EV_BUSY, EV_DET_EN, EV_DET_EX,
    EV_TMO, EV_GATE_DN, EV_UNG_EN, EV_UNG_EX, EV_IDLE, EV_DENY
  } ev_e;

  typedef struct {
    ev_e kind;
    int  cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  bit   last_entry = 1'b1;   // model: side served most recently (entry after reset)

  task automatic push(input ev_e k, input int c);
    exp_t r;
    r.kind = k;
    r.cyc  = c;
    exp_q.push_back(r);
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, required %b", name, act, exp);
  endtask

  task automatic see(input ev_e k);
    exp_t r;
    n_total++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_event: got %s at cycle %0d, required no event", k.name(), cyc);
    end else begin
      r = exp_q.pop_front();
      if (r.kind == k && r.cyc == cyc) n_pass++;
      else $display("FAIL event: got %s at cycle %0d, required %s at cycle %0d",
                    k.name(), cyc, r.kind.name(), r.cyc);
    end
  endtask

  // Monitor: turns output edges/pulses into events in a fixed per-cycle order
  initial begin
    logic p_eg, p_xg, p_go, p_busy;
    p_eg = 1'b0; p_xg = 1'b0; p_go = 1'b0; p_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        p_eg = 1'b0; p_xg = 1'b0; p_go = 1'b0; p_busy = 1'b0;
      end else begin
        if (entry_grant && !p_eg) see(EV_GRANT_EN);
        if (exit_grant && !p_xg)  see(EV_GRANT_EX);
        if (gate_open && !p_go)   see(EV_GATE_UP);
        if (busy && !p_busy)      see(EV_BUSY);
        if (entry_detected)       see(EV_DET_EN);
        if (exit_detected)        see(EV_DET_EX);
        if (timeout_err)          see(EV_TMO);
        if (!gate_open && p_go)   see(EV_GATE_DN);
        if (!entry_grant && p_eg) see(EV_UNG_EN);
        if (!exit_grant && p_xg)  see(EV_UNG_EX);
        if (!busy && p_busy)      see(EV_IDLE);
        if (entry_denied)         see(EV_DENY);
        p_eg = entry_grant; p_xg = exit_grant; p_go = gate_open; p_busy = busy;
      end
    end
  end

  // 0 = nobody served, 1 = entry, 2 = exit
  function automatic int pick(input bit en, input bit ex, input bit fu, input bit em);
    bit e_ok, x_ok;
    e_ok = en && !fu;
    x_ok = ex && !em;
    if (e_ok && x_ok) return last_entry ? 2 : 1;
    if (e_ok) return 1;
    if (x_ok) return 2;
    return 0;
  endfunction

  task automatic clear_inputs();
    entry_req = 1'b0; exit_req = 1'b0; pass_sensor = 1'b0;
    full_flag = 1'b0; empty_flag = 1'b0; obstruct = 1'b0;
  endtask

  task automatic reset_mid();
    #2 reset = 1'b1;
    clear_inputs();
    #1;
    chk("rst_mid_gate_open", gate_open, 1'b0);
    chk("rst_mid_entry_grant", entry_grant, 1'b0);
    chk("rst_mid_exit_grant", exit_grant, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    last_entry = 1'b1;
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
  endtask

  // One request window; pass_at = PASSING cycle index of the pass (>= PT means never in time)
  task automatic do_txn(input bit en, input bit ex, input bit fu, input bit em,
                        input int pass_at, input int obs_len, input int abort_k);
    int s, t, e, w, k;
    bit aborted;
    aborted = 1'b0;
    entry_req = en; exit_req = ex; full_flag = fu; empty_flag = em;
    pass_sensor = 1'b0; obstruct = 1'b0;
    s = cyc + 1;
    w = pick(en, ex, fu, em);
    if (w == 0) begin
      if (en && fu) push(EV_DENY, s);
      @(negedge clk);
      clear_inputs();
      @(negedge clk);
    end else begin
      last_entry = (w == 1);
      t = (pass_at < PT) ? s + OC + pass_at + 1 : s + OC + PT;
      e = (obs_len > 0) ? t + obs_len + 2 + OC : t + OC;
      push((w == 1) ? EV_GRANT_EN : EV_GRANT_EX, s);
      push(EV_GATE_UP, s);
      push(EV_BUSY, s);
      if (pass_at < PT) push((w == 1) ? EV_DET_EN : EV_DET_EX, t);
      else push(EV_TMO, t);
      push(EV_GATE_DN, t);
      if (obs_len > 0) begin
        push(EV_GATE_UP, t + 2);
        push(EV_GATE_DN, t + obs_len + 2);
      end
      push((w == 1) ? EV_UNG_EN : EV_UNG_EX, e);
      push(EV_IDLE, e);
      for (int n = 0; n < e - s; n++) begin
        @(negedge clk);
        k = cyc;
        if (abort_k >= 0 && k == s + OC + abort_k) begin
          reset_mid();
          aborted = 1'b1;
          break;
        end
        // requests and flags are noise outside IDLE; pass is exact only while PASSING
        entry_req  = ($urandom_range(0, 1) == 1);
        exit_req   = ($urandom_range(0, 1) == 1);
        full_flag  = ($urandom_range(0, 1) == 1);
        empty_flag = ($urandom_range(0, 1) == 1);
        if (k >= s + OC && k < t) pass_sensor = (k == s + OC + pass_at);
        else pass_sensor = ($urandom_range(0, 1) == 1);
        obstruct = (obs_len > 0) && (k >= t + 1) && (k <= t + obs_len);
      end
      if (!aborted) begin
        @(negedge clk);
        clear_inputs();
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1);
  end

  initial begin
    int gap;
    repeat (3) @(negedge clk);
    chk("rst_gate_open", gate_open, 1'b0);
    chk("rst_entry_grant", entry_grant, 1'b0);
    chk("rst_exit_grant", exit_grant, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_entry_detected", entry_detected, 1'b0);
    chk("rst_timeout_err", timeout_err, 1'b0);
    #1 reset = 1'b0;
    @(negedge clk);

    do_txn(1'b1, 1'b0, 1'b0, 1'b1, 2, 0, -1);   // plain entry with empty garage
    do_txn(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, -1);   // exit, pass on first PASSING cycle
    do_txn(1'b0, 1'b1, 1'b0, 1'b0, 10, 0, 1);   // exit aborted by reset in PASSING
    do_txn(1'b1, 1'b1, 1'b0, 1'b0, 3, 0, -1);   // first tie after reset: exit
    do_txn(1'b1, 1'b1, 1'b0, 1'b0, 1, 0, -1);   // second tie: entry
    do_txn(1'b1, 1'b0, 1'b1, 1'b0, 0, 0, -1);   // full: denied
    do_txn(1'b1, 1'b1, 1'b1, 1'b0, 5, 0, -1);   // full entry, exit served, no deny
    do_txn(1'b0, 1'b1, 1'b0, 1'b1, 0, 0, -1);   // exit while empty: ignored
    do_txn(1'b1, 1'b0, 1'b0, 1'b0, 1000, 0, -1);// no pass: timeout
    do_txn(1'b1, 1'b0, 1'b0, 1'b0, PT - 1, 0, -1); // pass on last PASSING cycle
`ifdef GATE_SAFETY_EN
    do_txn(1'b1, 1'b0, 1'b0, 1'b1, 0, 3, -1);   // obstruction in CLOSING cycle 2
`endif

    for (int i = 0; i < 60; i++) begin
      int obs;
      obs = 0;
`ifdef GATE_SAFETY_EN
      if ($urandom_range(0, 3) == 0) obs = int'($urandom_range(1, 3));
`endif
      do_txn(($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
             int'($urandom_range(0, 19)), obs, -1);
      gap = int'($urandom_range(0, 2));
      repeat (gap) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL pending_events: got %0d unseen events, required 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
